fetch_queue_stage: RTL and testbench

Parametrised IF stage with decoupled instruction-memory handshake, prefetch queue and IF/ID pipeline register. Issues sequential fetch requests to a variable-latency, in-order instruction memory and buffers returned instructions in a QDEPTH-entry queue. Drives the decode stage through a stallable, flushable IF/ID register. Handles branch/jump redirects from Execute by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_queue_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared constants and helpers for the instruction-fetch slice.
//   NOP_INSTR        : instruction shown to decode when the IF/ID register holds a bubble
//   DEFAULT_XLEN     : default address / PC width
//   DEFAULT_ILEN     : default instruction width
//   DEFAULT_RESET_PC : default PC after reset
//   cntWidth()       : counter width able to hold 0..depth inclusive
package fetch_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam int          DEFAULT_ILEN     = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Counters must be able to represent "completely full", hence depth+1 values.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO holding {pc, instr} pairs between the memory response
// path and the IF/ID register. Head data is presented combinationally.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   push_i  : write data_i (accepted when not full, or when full and popping)
//   pop_i   : discard head entry (ignored when empty)
//   flush_i : drop all contents; overrides push and pop
//   data_i  : entry to write
//   data_o  : head entry
//   count_o : number of valid entries
//   full_o  : count_o == DEPTH
//   empty_o : count_o == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [cntWidth(DEPTH)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cntWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, wrPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  // A full FIFO may still take a write in the same cycle its head leaves.
  assign doPush = push_i && (!full_o || pop_i);
  assign doPop  = pop_i && !empty_o;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
// Instruction-fetch stage: issues sequential requests to an in-order,
// variable-latency instruction memory, buffers responses in a prefetch
// queue and feeds decode through a stallable, flushable IF/ID register.
//   clk, rst (async, active-low)
//   PCSrcE / PCTargetE      : redirect from Execute and its target
//   StallD                  : hold the IF/ID register
//   imem_req_valid/addr     : fetch request, imem_req_ready accepts it
//   imem_rsp_valid/data     : in-order instruction responses
//   InstrD/PCD/PCPlus4D     : IF/ID register contents
//   ValidD                  : IF/ID holds a real instruction, not a bubble
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              ILEN     = DEFAULT_ILEN,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic [ILEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int CW = cntWidth(QDEPTH);
  localparam int EW = XLEN + ILEN;

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [XLEN-1:0] rspPc_q, rspPc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [ILEN-1:0] instrD_q, instrD_d;
  logic [XLEN-1:0] pcD_q, pcD_d;
  logic [XLEN-1:0] pcPlus4D_q, pcPlus4D_d;
  logic            validD_q, validD_d;

  logic [CW-1:0]   qCount;
  logic            qFull, qEmpty;
  logic [EW-1:0]   qHead;
  logic [CW:0]     inUse;
  logic            reqFire, rspKeep, qPush, qPop;

  // Every slot promised to an in-flight request is reserved in the queue,
  // so a response can never find the queue full.
  assign inUse          = {1'b0, qCount} + {1'b0, outstanding_q};
  assign imem_req_valid = rst && !PCSrcE && (inUse < (CW+1)'(QDEPTH));
  assign imem_req_addr  = fetchPc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // Responses to requests issued before a redirect are thrown away.
  assign rspKeep = imem_rsp_valid && !PCSrcE && (drop_q == '0);
  assign qPush   = rspKeep;
  assign qPop    = !PCSrcE && !StallD && !qEmpty;

  fetch_fifo #(
    .WIDTH(EW),
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (qPush),
    .pop_i  (qPop),
    .flush_i(PCSrcE),
    .data_i ({rspPc_q, imem_rsp_data}),
    .data_o (qHead),
    .count_o(qCount),
    .full_o (qFull),
    .empty_o(qEmpty)
  );

  // Fetch PC, response-PC tag and the two counters. Requests are always
  // sequential from the last redirect, so the PC of the next kept response
  // is simply a second counter reloaded on redirect.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    rspPc_d       = rspPc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (PCSrcE) begin
      fetchPc_d     = PCTargetE;
      rspPc_d       = PCTargetE;
      outstanding_d = outstanding_q - CW'(imem_rsp_valid);
      drop_d        = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (reqFire) fetchPc_d = fetchPc_q + XLEN'(4);
      if (rspKeep) rspPc_d = rspPc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      outstanding_d = outstanding_q + CW'(reqFire) - CW'(imem_rsp_valid);
    end
  end

  // IF/ID next state: redirect forces a bubble even under stall; otherwise a
  // stall holds everything and a free slot takes the queue head or a bubble.
  always_comb begin
    instrD_d   = instrD_q;
    pcD_d      = pcD_q;
    pcPlus4D_d = pcPlus4D_q;
    validD_d   = validD_q;
    if (PCSrcE || (!StallD && qEmpty)) begin
      instrD_d   = ILEN'(NOP_INSTR);
      pcD_d      = '0;
      pcPlus4D_d = '0;
      validD_d   = 1'b0;
    end else if (!StallD) begin
      instrD_d   = qHead[ILEN-1:0];
      pcD_d      = qHead[EW-1:ILEN];
      pcPlus4D_d = qHead[EW-1:ILEN] + XLEN'(4);
      validD_d   = 1'b1;
    end
  end

  // All architectural state of the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc_q     <= RESET_PC;
      rspPc_q       <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      instrD_q      <= ILEN'(NOP_INSTR);
      pcD_q         <= '0;
      pcPlus4D_q    <= '0;
      validD_q      <= 1'b0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      instrD_q      <= instrD_d;
      pcD_q         <= pcD_d;
      pcPlus4D_q    <= pcPlus4D_d;
      validD_q      <= validD_d;
    end
  end

  assign InstrD   = instrD_q;
  assign PCD      = pcD_q;
  assign PCPlus4D = pcPlus4D_q;
  assign ValidD   = validD_q;

  // A kept response landing in a full queue that is not draining means the
  // memory returned more responses than were requested.
  assert property (@(posedge clk) disable iff (!rst) !(qPush && qFull && !qPop));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage
// Directed and randomized bench for fetch_queue_stage. A behavioural memory
// (queue of accepted addresses with per-entry latency, data = ~address) and
// a stream model (decode must see consecutive PCs from the last reset or
// redirect) produce every expected value.
module tb_fetch_queue_stage;

  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic            clk;
  logic            rst;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            StallD;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic [ILEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;

  fetch_queue_stage #(
    .XLEN    (XLEN),
    .ILEN    (ILEN),
    .QDEPTH  (QDEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .StallD        (StallD),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .InstrD        (InstrD),
    .PCD           (PCD),
    .PCPlus4D      (PCPlus4D),
    .ValidD        (ValidD)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          readyCycle;
  } pend_t;

  pend_t       pend[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          lat = 1;
  logic [31:0] expReqAddr;
  logic [31:0] nextPc;
  logic        expValid;
  logic [31:0] expInstr, expPc, expPc4;
  bit          prevWaiting;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setBubble();
    expValid = 1'b0;
    expInstr = NOP;
    expPc    = '0;
    expPc4   = '0;
  endtask

  task automatic restartModel();
    pend.delete();
    expReqAddr  = RESET_PC;
    nextPc      = RESET_PC;
    prevWaiting = 1'b0;
    setBubble();
  endtask

  // One clock cycle: drive inputs at the falling edge, check the request
  // side just after, advance the memory model at the rising edge and check
  // the IF/ID outputs at the next falling edge.
  task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] tgt, input bit rdy);
    bit fire;
    bit rspNow;
    StallD         = stall;
    PCSrcE         = redir;
    PCTargetE      = tgt;
    imem_req_ready = rdy;
    rspNow         = (pend.size() > 0) && (pend[0].readyCycle <= cycle);
    imem_rsp_valid = rspNow;
    imem_rsp_data  = rspNow ? memData(pend[0].addr) : '0;
    #1;
    if (redir) checkOutput("req_during_redirect", imem_req_valid, 0);
    else if (prevWaiting) checkOutput("req_valid_held", imem_req_valid, 1);
    if (imem_req_valid) checkOutput("req_addr", imem_req_addr, expReqAddr);
    fire        = imem_req_valid && rdy;
    prevWaiting = imem_req_valid && !rdy;
    @(posedge clk);
    if (rspNow) void'(pend.pop_front());
    if (fire) begin
      pend.push_back('{expReqAddr, cycle + lat});
      expReqAddr = expReqAddr + 32'd4;
    end
    if (redir) begin
      expReqAddr = tgt;
      nextPc     = tgt;
      setBubble();
    end
    cycle++;
    checkOutput("outstanding_bound", 64'(pend.size() <= QDEPTH), 1);
    @(negedge clk);
    if (!redir && !stall) begin
      if (ValidD === 1'b1) begin
        expValid = 1'b1;
        expInstr = memData(nextPc);
        expPc    = nextPc;
        expPc4   = nextPc + 32'd4;
        nextPc   = nextPc + 32'd4;
      end else begin
        setBubble();
      end
    end
    checkOutput("ValidD", ValidD, expValid);
    checkOutput("InstrD", InstrD, expInstr);
    checkOutput("PCD", PCD, expPc);
    checkOutput("PCPlus4D", PCPlus4D, expPc4);
  endtask

  initial begin
    int firstValid;
    int nValid;
    rst            = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = '0;
    StallD         = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    restartModel();

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_InstrD", InstrD, NOP);
    checkOutput("reset_PCD", PCD, 0);
    checkOutput("reset_PCPlus4D", PCPlus4D, 0);
    checkOutput("reset_ValidD", ValidD, 0);
    checkOutput("reset_req_valid", imem_req_valid, 0);
    rst = 1'b1;

    // 1-cycle memory, always ready: ValidD first in the third cycle, then one per cycle
    lat = 1;
    firstValid = -1;
    nValid = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 0, '0, 1);
      if (ValidD === 1'b1) begin
        nValid++;
        if (firstValid < 0) firstValid = k;
      end
    end
    checkOutput("first_valid_cycle", 64'(firstValid), 2);
    checkOutput("throughput", 64'(nValid), 10);

    // Memory not ready for 5 cycles: request held, decode drains to bubbles
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, '0, 0);
    checkOutput("drained_ValidD", ValidD, 0);
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, '0, 1);

    // Decode stalled for 10 cycles: credit limit, held outputs, no loss on release
    for (int k = 0; k < 10; k++) applyStimulus(1, 0, '0, 1);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, '0, 1);

    // 3-cycle memory, redirect with responses in flight
    lat = 3;
    for (int k = 0; k < 10; k++) begin
      if (pend.size() >= 2) break;
      applyStimulus(0, 0, '0, 1);
    end
    checkOutput("two_in_flight", 64'(pend.size() >= 2), 1);
    applyStimulus(0, 1, 32'h100, 1);
    checkOutput("bubble_after_redirect", ValidD, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, '0, 1);
      if (ValidD === 1'b1) break;
    end
    checkOutput("redirect_first_pc", PCD, 32'h100);
    for (int k = 0; k < 6; k++) applyStimulus(0, 0, '0, 1);

    // Redirect while stalled with a response arriving in the same cycle
    lat = 2;
    for (int k = 0; k < 10; k++) begin
      if (pend.size() > 0 && pend[0].readyCycle <= cycle) break;
      applyStimulus(1, 0, '0, 1);
    end
    checkOutput("rsp_due", 64'(pend.size() > 0 && pend[0].readyCycle <= cycle), 1);
    applyStimulus(1, 1, 32'h200, 1);
    checkOutput("stall_redirect_bubble", ValidD, 0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, '0, 1);
      if (ValidD === 1'b1) break;
    end
    checkOutput("stall_redirect_pc", PCD, 32'h200);

    // PC wraps at the top of the address space
    lat = 1;
    applyStimulus(0, 1, 32'hFFFF_FFF8, 1);
    for (int k = 0; k < 10; k++) applyStimulus(0, 0, '0, 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      lat = int'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 3) == 0,
                    $urandom_range(0, 19) == 0,
                    32'($urandom_range(0, 1023)) << 2,
                    $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a stream
    lat = 1;
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, '0, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_InstrD", InstrD, NOP);
    checkOutput("midreset_PCD", PCD, 0);
    checkOutput("midreset_PCPlus4D", PCPlus4D, 0);
    checkOutput("midreset_ValidD", ValidD, 0);
    checkOutput("midreset_req_valid", imem_req_valid, 0);
    imem_rsp_valid = 1'b0;
    PCSrcE         = 1'b0;
    StallD         = 1'b0;
    restartModel();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    firstValid = -1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, '0, 1);
      if (ValidD === 1'b1 && firstValid < 0) begin
        firstValid = k;
        checkOutput("restart_pc", PCD, RESET_PC);
      end
    end
    checkOutput("restart_first_valid", 64'(firstValid), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
